// File: rtl/square_motion_ctrl.sv
// Frame-synchronous position controller for the 480p square painter: bounces the
// square once per frame and flags pixels inside it. Define SQUARE_BORDER_EN to also flag the screen border.
`timescale 1ns/1ps

module square_motion_ctrl #(
  parameter int CORDW   = 10,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int SQ_SIZE = 200,
  parameter int SPEED   = 2,
  parameter int X_INIT  = 220,
  parameter int Y_INIT  = 140
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             btn_pause,
  input  logic             btn_step,
  output logic [CORDW-1:0] sq_x,
  output logic [CORDW-1:0] sq_y,
  output logic             sq_hit,
  output logic             frame_tick,
  output logic             paused
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] PAUSE = 1'b1;

  localparam logic [CORDW:0] MAX_X  = (CORDW+1)'(H_RES - SQ_SIZE);
  localparam logic [CORDW:0] MAX_Y  = (CORDW+1)'(V_RES - SQ_SIZE);
  localparam logic [CORDW:0] SPD    = (CORDW+1)'(SPEED);
  localparam logic [CORDW:0] SQ_W   = (CORDW+1)'(SQ_SIZE);
  localparam logic [CORDW:0] HRES_W = (CORDW+1)'(H_RES);
  localparam logic [CORDW:0] VRES_W = (CORDW+1)'(V_RES);
`ifdef SQUARE_BORDER_EN
  localparam logic [CORDW:0] H_LAST = (CORDW+1)'(H_RES - 1);
  localparam logic [CORDW:0] V_LAST = (CORDW+1)'(V_RES - 1);
`endif

  // Button conditioning: [0],[1] synchronize, [2] holds the previous synced level.
  logic [2:0] pause_sr;
  logic [2:0] step_sr;
  logic       pause_edge;
  logic       step_edge;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      pause_sr <= '0;
      step_sr  <= '0;
    end else begin
      pause_sr <= {pause_sr[1:0], btn_pause};
      step_sr  <= {step_sr[1:0], btn_step};
    end
  end

  assign pause_edge = pause_sr[1] & ~pause_sr[2];
  assign step_edge  = step_sr[1] & ~step_sr[2];

  // Frame update point: first vblank pixel.
  logic tick_now;
  assign tick_now = (sx == '0) && ({1'b0, sy} == VRES_W);

  logic [0:0] state;
  logic       step_pend;
  logic       do_move;

  assign do_move = tick_now && ((state == RUN) || step_pend);

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state     <= RUN;
      step_pend <= 1'b0;
    end else if (pause_edge) begin
      // A simultaneous step edge is deliberately dropped here.
      state     <= (state == RUN) ? PAUSE : RUN;
      step_pend <= 1'b0;
    end else begin
      if (do_move) begin
        step_pend <= 1'b0;
      end
      if (step_edge && (state == PAUSE)) begin
        step_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      paused <= 1'b0;
    end else begin
      paused <= (state == PAUSE);
    end
  end

  // Returns {next_dir, next_pos}; dir 0 moves toward max_pos, 1 toward zero.
  function automatic logic [CORDW:0] axis_step(
    input logic [CORDW-1:0] pos,
    input logic             dir,
    input logic [CORDW:0]   max_pos
  );
    logic [CORDW:0] ext;
    logic [CORDW:0] sum;
    logic [CORDW:0] result;
    ext    = {1'b0, pos};
    sum    = '0;
    result = {dir, pos};
    if (!dir) begin
      sum = ext + SPD;
      if (sum >= max_pos) begin
        result = {1'b1, max_pos[CORDW-1:0]};
      end else begin
        result = {1'b0, sum[CORDW-1:0]};
      end
    end else begin
      if (ext <= SPD) begin
        result = {1'b0, {CORDW{1'b0}}};
      end else begin
        sum    = ext - SPD;
        result = {1'b1, sum[CORDW-1:0]};
      end
    end
    return result;
  endfunction

  logic           dir_x;
  logic           dir_y;
  logic [CORDW:0] nx_x;
  logic [CORDW:0] nx_y;

  always_comb begin
    nx_x = axis_step(sq_x, dir_x, MAX_X);
    nx_y = axis_step(sq_y, dir_y, MAX_Y);
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sq_x       <= CORDW'(X_INIT);
      sq_y       <= CORDW'(Y_INIT);
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick_now;
      if (do_move) begin
        sq_x  <= nx_x[CORDW-1:0];
        dir_x <= nx_x[CORDW];
        sq_y  <= nx_y[CORDW-1:0];
        dir_y <= nx_y[CORDW];
      end
    end
  end

  logic [CORDW:0] sx_e;
  logic [CORDW:0] sy_e;
  logic           active;
  logic           in_sq;
  logic           hit_next;

  always_comb begin
    sx_e   = {1'b0, sx};
    sy_e   = {1'b0, sy};
    active = (sx_e < HRES_W) && (sy_e < VRES_W);
    in_sq  = (sx_e >= {1'b0, sq_x}) && (sx_e < ({1'b0, sq_x} + SQ_W)) &&
             (sy_e >= {1'b0, sq_y}) && (sy_e < ({1'b0, sq_y} + SQ_W));
`ifdef SQUARE_BORDER_EN
    hit_next = active && (in_sq || (sx == '0) || (sx_e == H_LAST) ||
                                   (sy == '0) || (sy_e == V_LAST));
`else
    hit_next = active && in_sq;
`endif
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sq_hit <= 1'b0;
    end else begin
      sq_hit <= hit_next;
    end
  end

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Bench for square_motion_ctrl: vector table, directed bounce/pause/step sequences,
// and a randomized phase against a triangle-wave position model.
`timescale 1ns/1ps

module tb_square_motion_ctrl;

  localparam int CORDW   = 10;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int SQ_SIZE = 200;
  localparam int SPEED   = 2;
  localparam int X_INIT  = 220;
  localparam int Y_INIT  = 140;
  localparam int MAX_X   = H_RES - SQ_SIZE;
  localparam int MAX_Y   = V_RES - SQ_SIZE;
`ifdef SQUARE_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  // clock / reset
  logic             clk_pix = 1'b0;
  logic             rst_pix;
  logic [CORDW-1:0] sx, sy;
  logic             btn_pause, btn_step;
  logic [CORDW-1:0] sq_x, sq_y;
  logic             sq_hit, frame_tick, paused;

  always #5 clk_pix = ~clk_pix;

  square_motion_ctrl dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy),
    .btn_pause(btn_pause), .btn_step(btn_step),
    .sq_x(sq_x), .sq_y(sq_y), .sq_hit(sq_hit),
    .frame_tick(frame_tick), .paused(paused)
  );

  // scoreboard state and reference model
  int   total = 0;
  int   bad   = 0;
  int   n_moves;
  bit   m_paused;
  bit   m_step;
  logic exp_q[$];

  // Position as a triangle wave over the number of moves made so far.
  function automatic int tri_pos(input int init, input int maxv, input int n);
    int u;
    u = (init + n * SPEED) % (2 * maxv);
    return (u <= maxv) ? u : 2 * maxv - u;
  endfunction

  function automatic int exp_x();
    return tri_pos(X_INIT, MAX_X, n_moves);
  endfunction

  function automatic int exp_y();
    return tri_pos(Y_INIT, MAX_Y, n_moves);
  endfunction

  function automatic logic exp_hit(input int x, input int y);
    int px, py;
    px = exp_x();
    py = exp_y();
    if (x >= H_RES || y >= V_RES) return 1'b0;
    if (BORDER && (x == 0 || x == H_RES - 1 || y == 0 || y == V_RES - 1)) return 1'b1;
    return (x >= px && x < px + SQ_SIZE && y >= py && y < py + SQ_SIZE);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (moves=%0d)", name, act, exp, n_moves);
    end
  endtask

  // driver tasks: inputs change on the falling edge, outputs sampled on the next one
  task automatic cyc(input int x, input int y);
    sx = CORDW'(x);
    sy = CORDW'(y);
    @(negedge clk_pix);
  endtask

  task automatic probe(input int x, input int y);
    exp_q.push_back(exp_hit(x, y));
    cyc(x, y);
    check("sq_hit", 32'(sq_hit), 32'(exp_q.pop_front()));
    check("tick_idle", 32'(frame_tick), 32'd0);
  endtask

  task automatic do_tick();
    if (!m_paused || m_step) begin
      n_moves++;
      m_step = 1'b0;
    end
    cyc(0, V_RES);
    check("frame_tick", 32'(frame_tick), 32'd1);
    check("sq_x", 32'(sq_x), 32'(exp_x()));
    check("sq_y", 32'(sq_y), 32'(exp_y()));
    cyc(1, V_RES);
    check("tick_width", 32'(frame_tick), 32'd0);
  endtask

  task automatic press(input bit p, input bit s);
    btn_pause = p;
    btn_step  = s;
    repeat (4) cyc(700, 10);
    btn_pause = 1'b0;
    btn_step  = 1'b0;
    repeat (4) cyc(700, 10);
    if (p) begin
      m_paused = !m_paused;
      m_step   = 1'b0;
    end else if (s && m_paused) begin
      m_step = 1'b1;
    end
    check("paused", 32'(paused), 32'(m_paused));
  endtask

  typedef struct {
    int   x;
    int   y;
    logic hit;
  } vec_t;

  vec_t vt[12];

  initial begin
    int x0, y0, r, px, py;

    vt[0]  = '{220, 140, 1'b1};
    vt[1]  = '{419, 339, 1'b1};
    vt[2]  = '{420, 140, 1'b0};
    vt[3]  = '{219, 140, 1'b0};
    vt[4]  = '{220, 340, 1'b0};
    vt[5]  = '{300, 200, 1'b1};
    vt[6]  = '{0,   0,   BORDER};
    vt[7]  = '{639, 100, BORDER};
    vt[8]  = '{100, 479, BORDER};
    vt[9]  = '{700, 200, 1'b0};
    vt[10] = '{300, 480, 1'b0};
    vt[11] = '{220, 339, 1'b1};

    n_moves = 0; m_paused = 1'b0; m_step = 1'b0;
    btn_pause = 1'b0; btn_step = 1'b0;
    rst_pix = 1'b1;
    sx = CORDW'(700); sy = CORDW'(10);
    @(negedge clk_pix);
    cyc(700, 10);
    check("rst_sq_x", 32'(sq_x), 32'd220);
    check("rst_sq_y", 32'(sq_y), 32'd140);
    check("rst_hit", 32'(sq_hit), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_paused", 32'(paused), 32'd0);
    rst_pix = 1'b0;
    cyc(700, 10);

    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].x, vt[i].y);
      check($sformatf("vec%0d_hit", i), 32'(sq_hit), 32'(vt[i].hit));
    end

    // free run: three frames
    do_tick(); check("run1_x", 32'(sq_x), 32'd222); check("run1_y", 32'(sq_y), 32'd142);
    do_tick(); check("run2_x", 32'(sq_x), 32'd224); check("run2_y", 32'(sq_y), 32'd144);
    do_tick(); check("run3_x", 32'(sq_x), 32'd226); check("run3_y", 32'(sq_y), 32'd146);
    for (int i = 0; i < 4; i++) begin
      probe($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1));
      check("const_x", 32'(sq_x), 32'd226);
    end

    // bounce off both edges, through x reaching zero
    while (n_moves < 331) begin
      do_tick();
      if (n_moves == 70)  check("bounce_y280", 32'(sq_y), 32'd280);
      if (n_moves == 71)  check("bounce_y278", 32'(sq_y), 32'd278);
      if (n_moves == 110) check("bounce_x440", 32'(sq_x), 32'd440);
      if (n_moves == 111) check("bounce_x438", 32'(sq_x), 32'd438);
      if (n_moves == 330) check("bounce_x0", 32'(sq_x), 32'd0);
      if (n_moves == 331) check("bounce_x2", 32'(sq_x), 32'd2);
    end

    // pause latency: paused rises on the fourth edge after the button
    btn_pause = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc(700, 10);
      check($sformatf("pause_lat%0d", i), 32'(paused), (i == 4) ? 32'd1 : 32'd0);
    end
    btn_pause = 1'b0;
    repeat (4) cyc(700, 10);
    m_paused = 1'b1;
    x0 = int'(sq_x); y0 = int'(sq_y);
    repeat (5) do_tick();
    check("pause_hold_x", 32'(sq_x), 32'(x0));
    check("pause_hold_y", 32'(sq_y), 32'(y0));

    // two steps between ticks yield a single move
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    do_tick();
    check("step_moved", 32'(sq_x != CORDW'(x0)), 32'd1);
    x0 = int'(sq_x);
    do_tick();
    check("step_once", 32'(sq_x), 32'(x0));

    // pause and step together: toggles state, step dropped
    press(1'b1, 1'b1);
    do_tick();
    press(1'b1, 1'b1);
    x0 = int'(sq_x);
    do_tick();
    check("ps_no_move", 32'(sq_x), 32'(x0));
    press(1'b1, 1'b0);
    do_tick();

    // randomized phase
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r < 12) begin
        px = $urandom_range(0, 799);
        py = $urandom_range(0, 524);
        if (px == 0 && py == V_RES) px = 1;
        probe(px, py);
      end else if (r < 15) begin
        px = exp_x() + $urandom_range(0, SQ_SIZE + 1) - 1;
        py = exp_y() + $urandom_range(0, SQ_SIZE + 1) - 1;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        probe(px, py);
      end else if (r < 18) begin
        do_tick();
      end else if (r == 18) begin
        press(1'b1, 1'b0);
      end else begin
        press(1'b0, 1'b1);
      end
    end

    // reset mid-frame while paused and displaced
    if (!m_paused) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    do_tick();
    rst_pix = 1'b1;
    cyc(300, 200);
    rst_pix = 1'b0;
    n_moves = 0; m_paused = 1'b0; m_step = 1'b0;
    check("mrst_x", 32'(sq_x), 32'd220);
    check("mrst_y", 32'(sq_y), 32'd140);
    check("mrst_paused", 32'(paused), 32'd0);
    check("mrst_hit", 32'(sq_hit), 32'd0);
    probe(220, 140);
    probe(420, 140);
    do_tick();
    check("mrst_run_x", 32'(sq_x), 32'd222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
